swing_seq_ctrl: RTL and testbench

- Parametrised successor to the track balance/swing state sequencer.
- Drives the main-axis motor `direct`/`enable` pair through balance, limit-switch-bounded swing rounds and a geometrically decaying damping oscillation.
- Adds configurable round count, decay rate and stop threshold, key edge detection, limit-switch timeout fault, abort, status outputs, and an optional reversal dead-time.
- Sits between key/sensor conditioning and the stepper/motor driver.

---
 rtl/swing_pkg.sv | 19 +
 rtl/swing_seq_ctrl_if.sv | 25 ++
 rtl/swing_damp_gen.sv | 65 ++++++
 rtl/swing_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_swing_seq_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/swing_pkg.sv
// rtl/swing_pkg.sv - shared state encoding and default constants for the swing sequencer
package swing_pkg;

  localparam int ROUNDS_DEF  = 6;
  localparam int CNT_W_DEF   = 27;
  localparam int PERIOD_DEF  = 100_000_000;
  localparam int TIMEOUT_DEF = 200_000_000;

  typedef enum logic [6:0] {
    ST_IDLE    = 7'b000_0001,
    ST_BALANCE = 7'b000_0010,
    ST_WAIT    = 7'b000_0100,
    ST_SWING_R = 7'b000_1000,
    ST_SWING_L = 7'b001_0000,
    ST_DAMP    = 7'b010_0000,
    ST_FAULT   = 7'b100_0000
  } state_t;

endpackage

// File: rtl/swing_seq_ctrl_if.sv
// rtl/swing_seq_ctrl_if.sv - key/sensor inputs and motor/status outputs of the swing sequencer
interface swing_seq_ctrl_if #(
  parameter int RC_W = 3
);
  logic            key;
  logic            abort;
  logic            catcher;
  logic            jockey_r;
  logic            jockey_l;
  logic            direct;
  logic            enable;
  logic            busy;
  logic            fault;
  logic [RC_W-1:0] round_cnt;

  modport master (
    output key, abort, catcher, jockey_r, jockey_l,
    input  direct, enable, busy, fault, round_cnt
  );

  modport slave (
    input  key, abort, catcher, jockey_r, jockey_l,
    output direct, enable, busy, fault, round_cnt
  );
endinterface

// File: rtl/swing_damp_gen.sv
// rtl/swing_damp_gen.sv - decaying half-period generator for the damping oscillation
module swing_damp_gen #(
  parameter int CNT_W    = 27,
  parameter int PERIOD   = 100_000_000,
  parameter int DECAY_SH = 1,
  parameter int MIN_HALF = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_abort,
  output logic o_dir,
  output logic o_done
);
  localparam logic [CNT_W-1:0] PERIOD_H = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] MIN_H    = CNT_W'(MIN_HALF);

  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_timer;
  logic             r_dir;
  logic             r_active;

  logic [CNT_W-1:0] w_next_half;
  logic             w_end;
  logic             w_stop;

  assign w_next_half = r_half >> DECAY_SH;
  assign w_end       = r_active && (r_timer == r_half - CNT_W'(1));
  assign w_stop      = w_next_half < MIN_H;
  assign o_done      = w_end && w_stop;
  assign o_dir       = r_dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half   <= '0;
      r_timer  <= '0;
      r_dir    <= 1'b0;
      r_active <= 1'b0;
    end else if (i_abort) begin
      r_half   <= '0;
      r_timer  <= '0;
      r_dir    <= 1'b0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_half   <= PERIOD_H;
      r_timer  <= '0;
      r_dir    <= 1'b1;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (w_end) begin
        r_timer <= '0;
        // The final half-period ends without a reversal; the sequencer leaves DAMP.
        if (w_stop) begin
          r_active <= 1'b0;
          r_half   <= '0;
        end else begin
          r_dir  <= ~r_dir;
          r_half <= w_next_half;
        end
      end else begin
        r_timer <= r_timer + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/swing_seq_ctrl.sv
// rtl/swing_seq_ctrl.sv - balance/swing/damping sequencer for the main-axis motor (option: SWING_DEADTIME_EN)
module swing_seq_ctrl
  import swing_pkg::*;
#(
  parameter int ROUNDS   = ROUNDS_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PERIOD   = PERIOD_DEF,
  parameter int DECAY_SH = 1,
  parameter int MIN_HALF = 1,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int DEADTIME = 1000
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  swing_seq_ctrl_if.slave  bus
);
  localparam int               RC_W     = $clog2(ROUNDS + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(ROUNDS);

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [RC_W-1:0]  r_round_cnt;
  logic             r_key_d;
  logic             r_direct;
  logic             r_enable;
  logic             r_busy;
  logic             r_fault;

  logic             w_key_rise;
  logic [RC_W-1:0]  w_rc_inc;
  logic             w_start;
  logic             w_dir;
  logic             w_done;
  logic             w_en_dec;
  logic             w_dir_dec;

  assign w_key_rise = bus.key & ~r_key_d;
  assign w_rc_inc   = r_round_cnt + RC_W'(1);
  assign w_start    = !bus.abort && (r_state == ST_SWING_L) && !bus.jockey_l && (w_rc_inc == RC_MAX);

  swing_damp_gen #(
    .CNT_W    (CNT_W),
    .PERIOD   (PERIOD),
    .DECAY_SH (DECAY_SH),
    .MIN_HALF (MIN_HALF)
  ) u_damp (
    .clk     (sclk),
    .rst_n   (s_rst_n),
    .i_start (w_start),
    .i_abort (bus.abort),
    .o_dir   (w_dir),
    .o_done  (w_done)
  );

  always_comb begin
    w_en_dec  = 1'b0;
    w_dir_dec = 1'b0;
    case (r_state)
      ST_BALANCE: w_en_dec = 1'b1;
      ST_SWING_R: begin
        w_en_dec  = 1'b1;
        w_dir_dec = 1'b1;
      end
      ST_SWING_L: w_en_dec = 1'b1;
      ST_DAMP: begin
        w_en_dec  = 1'b1;
        w_dir_dec = w_dir;
      end
      default: ;
    endcase
  end

`ifdef SWING_DEADTIME_EN
  localparam int              DT_W    = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME - 1);
  logic [DT_W-1:0] r_dt;
`else
  wire [31:0] w_unused_deadtime = 32'(DEADTIME);
`endif

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_round_cnt <= '0;
      r_key_d     <= 1'b0;
      r_direct    <= 1'b0;
      r_enable    <= 1'b0;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
`ifdef SWING_DEADTIME_EN
      r_dt        <= '0;
`endif
    end else begin
      r_key_d  <= bus.key;
      r_direct <= w_dir_dec;
      r_busy   <= !(r_state == ST_IDLE || r_state == ST_FAULT);
      r_fault  <= (r_state == ST_FAULT);
`ifdef SWING_DEADTIME_EN
      // A reversal while driving opens the dead-time window in the same cycle direct flips.
      if (bus.abort) begin
        r_dt     <= '0;
        r_enable <= w_en_dec;
      end else if (w_en_dec && (r_enable || r_dt != '0) && (w_dir_dec != r_direct)) begin
        r_dt     <= DT_LAST;
        r_enable <= 1'b0;
      end else if (r_dt != '0) begin
        r_dt     <= r_dt - DT_W'(1);
        r_enable <= 1'b0;
      end else begin
        r_enable <= w_en_dec;
      end
`else
      r_enable <= w_en_dec;
`endif

      if (bus.abort) begin
        r_state     <= ST_IDLE;
        r_timer     <= '0;
        r_round_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE:    if (w_key_rise) r_state <= ST_BALANCE;
          ST_BALANCE: if (!bus.catcher) r_state <= ST_WAIT;
          ST_WAIT: begin
            if (w_key_rise) begin
              r_state     <= ST_SWING_R;
              r_round_cnt <= '0;
              r_timer     <= '0;
            end
          end
          ST_SWING_R: begin
            if (!bus.jockey_r) begin
              r_state <= ST_SWING_L;
              r_timer <= '0;
            end else if (r_timer == TMO_LAST) begin
              r_state <= ST_FAULT;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + CNT_W'(1);
            end
          end
          ST_SWING_L: begin
            if (!bus.jockey_l) begin
              r_round_cnt <= w_rc_inc;
              r_timer     <= '0;
              r_state     <= (w_rc_inc == RC_MAX) ? ST_DAMP : ST_SWING_R;
            end else if (r_timer == TMO_LAST) begin
              r_state <= ST_FAULT;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + CNT_W'(1);
            end
          end
          ST_DAMP:  if (w_done) r_state <= ST_IDLE;
          ST_FAULT: if (w_key_rise) r_state <= ST_IDLE;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.direct    = r_direct;
  assign bus.enable    = r_enable;
  assign bus.busy      = r_busy;
  assign bus.fault     = r_fault;
  assign bus.round_cnt = r_round_cnt;
endmodule

// File: tb/tb_swing_seq_ctrl.sv
// tb/tb_swing_seq_ctrl.sv - randomized scenario bench for swing_seq_ctrl against a phase-level model
module tb_swing_seq_ctrl;
  localparam int ROUNDS   = 2;
  localparam int CNT_W    = 8;
  localparam int PERIOD   = 16;
  localparam int DECAY_SH = 1;
  localparam int MIN_HALF = 2;
  localparam int TIMEOUT  = 50;
  localparam int DEADTIME = 3;
  localparam int RC_W     = $clog2(ROUNDS + 1);

  // Phase labels describe what the controller is doing, not how it is encoded.
  localparam int P_IDLE = 0, P_BAL = 1, P_WAIT = 2, P_R = 3, P_L = 4, P_D1 = 5, P_D0 = 6, P_FAULT = 7;

  logic sclk = 1'b0;
  logic s_rst_n = 1'b0;
  always #5 sclk = ~sclk;

  swing_seq_ctrl_if #(.RC_W(RC_W)) bus ();

  swing_seq_ctrl #(
    .ROUNDS(ROUNDS), .CNT_W(CNT_W), .PERIOD(PERIOD), .DECAY_SH(DECAY_SH),
    .MIN_HALF(MIN_HALF), .TIMEOUT(TIMEOUT), .DEADTIME(DEADTIME)
  ) dut (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .bus     (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;
  int m_cur = P_IDLE;
  int m_rc = 0;
  int m_step = 0;
  int m_abort_at = -1;
  bit m_ab = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // {direct, enable, busy, fault} expected while the controller sits in a phase.
  function automatic logic [3:0] outs_of(input int ph);
    case (ph)
      P_BAL:   return 4'b0110;
      P_WAIT:  return 4'b0010;
      P_R:     return 4'b1110;
      P_L:     return 4'b0110;
      P_D1:    return 4'b1110;
      P_D0:    return 4'b0110;
      P_FAULT: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input logic k, input logic c, input logic jr, input logic jl,
                     input int nxt, input int rc);
    logic ab;
    int   n;
    ab = 1'b0;
    n  = nxt;
    if (m_ab) begin
      k = 1'b0; c = 1'b1; jr = 1'b1; jl = 1'b1; n = P_IDLE;
    end else if (m_step == m_abort_at) begin
      ab = 1'b1; n = P_IDLE; m_rc = 0; m_ab = 1'b1;
    end else if (rc >= 0) begin
      m_rc = rc;
    end
    bus.key = k; bus.abort = ab; bus.catcher = c; bus.jockey_r = jr; bus.jockey_l = jl;
    m_step++;
    @(posedge sclk);
    #1;
    check($sformatf("outs[ph%0d]", m_cur), 32'({bus.direct, bus.enable, bus.busy, bus.fault}),
          32'(outs_of(m_cur)));
    check("round_cnt", 32'(bus.round_cnt), 32'(m_rc));
    m_cur = n;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, P_IDLE, -1);
  endtask

  task automatic prelude();
    int n;
    n = $urandom_range(1, 10);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, P_BAL, -1);
    n = $urandom_range(0, 5);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, rb(), rb(), P_BAL, -1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, P_WAIT, -1);
    n = $urandom_range(0, 5);
    for (int i = 0; i < n; i++) cyc(1'b0, rb(), 1'b1, 1'b1, P_WAIT, -1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, P_R, 0);
  endtask

  task automatic side(input bit right, input bit to_fault, input int r);
    int d;
    int self_ph;
    self_ph = right ? P_R : P_L;
    d = to_fault ? TIMEOUT - 1 : $urandom_range(0, TIMEOUT - 1);
    for (int i = 0; i < d; i++)
      cyc(1'b0, 1'b1, right ? 1'b1 : rb(), right ? rb() : 1'b1, self_ph, -1);
    if (to_fault)
      cyc(1'b0, 1'b1, right ? 1'b1 : rb(), right ? rb() : 1'b1, P_FAULT, -1);
    else if (right)
      cyc(1'b0, 1'b1, 1'b0, rb(), P_L, -1);
    else
      cyc(1'b0, 1'b1, rb(), 1'b0, (r == ROUNDS) ? P_D1 : P_R, r);
  endtask

  task automatic damp();
    int h;
    int nh;
    int ph;
    h  = PERIOD;
    ph = P_D1;
    forever begin
      for (int i = 0; i < h - 1; i++) cyc(1'b0, rb(), rb(), rb(), ph, -1);
      nh = h >> DECAY_SH;
      if (nh < MIN_HALF) begin
        cyc(1'b0, rb(), rb(), rb(), P_IDLE, -1);
        break;
      end
      ph = (ph == P_D1) ? P_D0 : P_D1;
      cyc(1'b0, rb(), rb(), rb(), ph, -1);
      h = nh;
    end
  endtask

  task automatic start_run(input bit allow_abort);
    m_step = 0;
    m_ab = 1'b0;
    m_abort_at = (allow_abort && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 220)) : -1;
  endtask

  task automatic run_normal(input bit allow_abort);
    start_run(allow_abort);
    prelude();
    for (int r = 1; r <= ROUNDS; r++) begin
      side(1'b1, 1'b0, r);
      side(1'b0, 1'b0, r);
    end
    damp();
    idle(3);
  endtask

  task automatic run_fault(input bit allow_abort);
    int  fr;
    bit  fs;
    bit  fright;
    int  n;
    start_run(allow_abort);
    fr = $urandom_range(1, ROUNDS);
    fs = rb();
    prelude();
    for (int r = 1; r <= fr; r++) begin
      fright = (r == fr) && fs;
      side(1'b1, fright, r);
      if (fright) break;
      side(1'b0, r == fr, r);
    end
    n = $urandom_range(0, 5);
    for (int i = 0; i < n; i++) cyc(1'b0, rb(), rb(), rb(), P_FAULT, -1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, P_IDLE, -1);
    idle(3);
  endtask

  initial begin
    bus.key = 1'b0; bus.abort = 1'b0; bus.catcher = 1'b1; bus.jockey_r = 1'b1; bus.jockey_l = 1'b1;
    s_rst_n = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    check("reset_outs", 32'({bus.direct, bus.enable, bus.busy, bus.fault}), 32'h0);
    check("reset_round_cnt", 32'(bus.round_cnt), 32'h0);
    s_rst_n = 1'b1;
    idle(2);
    run_normal(1'b0);
    run_fault(1'b0);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) run_fault(1'b1);
      else run_normal(1'b1);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
